// File: rtl/osc_clk_monitor.sv
// Oscillator health monitor: counts rising edges of an asynchronous oscillator
// over a fixed CLK window and flags windows whose count leaves the programmed band.

module osc_clk_monitor #(
  parameter int WIN_CYCLES   = 50000,
  parameter int CNT_W        = 16,
  parameter int MIN_EDGES    = 900,
  parameter int MAX_EDGES    = 1100,
  parameter int FAIL_WINDOWS = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             OSC_IN,
  input  logic             EN,
  input  logic             FAIL_CLR,
  output logic [CNT_W-1:0] EDGE_COUNT,
  output logic             COUNT_VALID,
  output logic             OSC_OK,
  output logic             OSC_FAIL
);

  localparam int               WIN_W    = 24;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ZERO = 24'd0;
  localparam logic [WIN_W-1:0] WIN_ONE  = 24'd1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      MIN_U    = 32'(MIN_EDGES);
  localparam logic [31:0]      MAX_U    = 32'(MAX_EDGES);
  localparam logic [3:0]       FAIL_LIM = 4'(FAIL_WINDOWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  state_t           state_r;
  logic             sync1_r;
  logic             sync2_r;
  logic             sync3_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [3:0]       bad_cnt_r;

  logic             rise_s;
  logic [CNT_W-1:0] edge_inc_s;
  logic             in_band_s;
  logic [3:0]       bad_next_s;
  logic             fail_set_s;

  // The counter sticks at all-ones so an overspeed oscillator can never wrap back into band.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  function automatic logic band_check(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    band_check = (w >= MIN_U) && (w <= MAX_U);
  endfunction

  // Edge detect, saturating increments and the failure decision for the EVAL cycle.
  always_comb begin
    rise_s     = sync2_r & ~sync3_r;
    edge_inc_s = sat_inc(edge_cnt_r);
    in_band_s  = band_check(edge_cnt_r);
    if (bad_cnt_r >= FAIL_LIM) begin
      bad_next_s = FAIL_LIM;
    end else begin
      bad_next_s = bad_cnt_r + 4'd1;
    end
    if ((state_r == ST_EVAL) && !in_band_s && (bad_next_s == FAIL_LIM)) begin
      fail_set_s = 1'b1;
    end else begin
      fail_set_s = 1'b0;
    end
  end

  // Synchronizer, window FSM, edge counter and registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_r     <= ST_IDLE;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      sync3_r     <= 1'b0;
      win_cnt_r   <= WIN_ZERO;
      edge_cnt_r  <= CNT_ZERO;
      bad_cnt_r   <= 4'd0;
      EDGE_COUNT  <= CNT_ZERO;
      COUNT_VALID <= 1'b0;
      OSC_OK      <= 1'b0;
      OSC_FAIL    <= 1'b0;
    end else begin
      sync1_r     <= OSC_IN;
      sync2_r     <= sync1_r;
      sync3_r     <= sync2_r;
      COUNT_VALID <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          win_cnt_r  <= WIN_ZERO;
          edge_cnt_r <= CNT_ZERO;
          if (EN) begin
            state_r <= ST_MEAS;
          end
        end

        ST_MEAS: begin
          if (!EN) begin
            // Partial window is discarded; status outputs keep their last values.
            state_r    <= ST_IDLE;
            win_cnt_r  <= WIN_ZERO;
            edge_cnt_r <= CNT_ZERO;
          end else begin
            if (rise_s) begin
              edge_cnt_r <= edge_inc_s;
            end
            if (win_cnt_r == WIN_LAST) begin
              state_r   <= ST_EVAL;
              win_cnt_r <= WIN_ZERO;
            end else begin
              win_cnt_r <= win_cnt_r + WIN_ONE;
            end
          end
        end

        ST_EVAL: begin
          EDGE_COUNT  <= edge_cnt_r;
          COUNT_VALID <= 1'b1;
          win_cnt_r   <= WIN_ZERO;
          if (in_band_s) begin
            bad_cnt_r <= 4'd0;
            OSC_OK    <= 1'b1;
          end else begin
            bad_cnt_r <= bad_next_s;
            if (bad_next_s == FAIL_LIM) begin
              OSC_OK <= 1'b0;
            end
          end
          // An edge arriving during EVAL belongs to the next window.
          if (EN) begin
            state_r    <= ST_MEAS;
            edge_cnt_r <= rise_s ? CNT_ONE : CNT_ZERO;
          end else begin
            state_r    <= ST_IDLE;
            edge_cnt_r <= CNT_ZERO;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          win_cnt_r  <= WIN_ZERO;
          edge_cnt_r <= CNT_ZERO;
        end
      endcase

      // A failing evaluation beats a simultaneous clear request.
      if (fail_set_s) begin
        OSC_FAIL <= 1'b1;
      end else if (FAIL_CLR) begin
        OSC_FAIL <= 1'b0;
      end
    end
  end

  osc_clk_monitor_chk #(
    .FAIL_WINDOWS(FAIL_WINDOWS)
  ) u_chk (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .COUNT_VALID(COUNT_VALID),
    .state      (state_r),
    .bad_cnt    (bad_cnt_r)
  );

endmodule

// Structural properties of the monitor: single-cycle result pulse, bounded
// bad-window counter and no unreachable state encoding.
module osc_clk_monitor_chk #(
  parameter int FAIL_WINDOWS = 2
) (
  input logic       CLK,
  input logic       RESETN,
  input logic       COUNT_VALID,
  input logic [1:0] state,
  input logic [3:0] bad_cnt
);

  a_cv_pulse: assert property (@(posedge CLK) disable iff (!RESETN)
    COUNT_VALID |=> !COUNT_VALID);

  a_bad_bound: assert property (@(posedge CLK) disable iff (!RESETN)
    bad_cnt <= 4'(FAIL_WINDOWS));

  a_state_legal: assert property (@(posedge CLK) disable iff (!RESETN)
    state != 2'd3);

endmodule

// File: tb/tb_osc_clk_monitor.sv
// Directed bench for osc_clk_monitor: nominal, stuck, overspeed, clear/set,
// EN abort and mid-window reset, with hand-computed expectations.

module tb_osc_clk_monitor;

  logic        clk;
  logic        resetn;
  logic        osc;
  logic        osc2;
  logic        en;
  logic        en2;
  logic        fail_clr;
  logic        fail_clr2;
  logic [15:0] edge_count;
  logic        count_valid;
  logic        osc_ok;
  logic        osc_fail;
  logic [3:0]  edge_count2;
  logic        count_valid2;
  logic        osc_ok2;
  logic        osc_fail2;

  int checks = 0;
  int errors = 0;
  int osc_period = 0;

  osc_clk_monitor #(
    .WIN_CYCLES(100), .CNT_W(16), .MIN_EDGES(9), .MAX_EDGES(11), .FAIL_WINDOWS(2)
  ) dut (
    .CLK(clk), .RESETN(resetn), .OSC_IN(osc), .EN(en), .FAIL_CLR(fail_clr),
    .EDGE_COUNT(edge_count), .COUNT_VALID(count_valid), .OSC_OK(osc_ok), .OSC_FAIL(osc_fail)
  );

  osc_clk_monitor #(
    .WIN_CYCLES(100), .CNT_W(4), .MIN_EDGES(9), .MAX_EDGES(11), .FAIL_WINDOWS(2)
  ) dut_sat (
    .CLK(clk), .RESETN(resetn), .OSC_IN(osc2), .EN(en2), .FAIL_CLR(fail_clr2),
    .EDGE_COUNT(edge_count2), .COUNT_VALID(count_valid2), .OSC_OK(osc_ok2), .OSC_FAIL(osc_fail2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator models: osc has a programmable period (0 = stuck low, phase restarts
  // high on every period change); osc2 toggles every cycle (period 2).
  initial begin
    int phase;
    int prev;
    phase = 0;
    prev  = 0;
    osc   = 1'b0;
    osc2  = 1'b0;
    forever begin
      @(negedge clk);
      osc2 = ~osc2;
      if (osc_period != prev) begin
        phase = 0;
        prev  = osc_period;
      end
      if (osc_period == 0) begin
        osc = 1'b0;
      end else begin
        osc   = (phase < osc_period / 2);
        phase = (phase + 1) % osc_period;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the selected COUNT_VALID and checks how many edges it took.
  task automatic wait_cv(input bit sel, input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((sel ? count_valid2 : count_valid) !== 1'b1) && (n < 400));
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int cv_seen;
    resetn    = 1'b0;
    en        = 1'b0;
    en2       = 1'b0;
    fail_clr  = 1'b0;
    fail_clr2 = 1'b0;

    // Reset state
    tick(2);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    check("rst_osc_ok", 32'(osc_ok), 32'd0);
    check("rst_osc_fail", 32'(osc_fail), 32'd0);
    check("rst_sat_ok", 32'(osc_ok2), 32'd0);

    // Nominal clock, period 10; running well before EN so the pipeline is primed
    osc_period = 10;
    resetn = 1'b1;
    tick(20);
    en = 1'b1;
    tick(1);                                   // now in MEAS
    wait_cv(1'b0, "first_window_latency", 101);
    check("first_window_count", 32'(edge_count), 32'd10);
    check("first_window_ok", 32'(osc_ok), 32'd1);
    check("first_window_fail", 32'(osc_fail), 32'd0);
    tick(1);
    check("count_valid_pulse", 32'(count_valid), 32'd0);
    wait_cv(1'b0, "window2_period", 100);
    check("window2_count_band", 32'((edge_count >= 16'd10) && (edge_count <= 16'd11)), 32'd1);
    check("window2_ok", 32'(osc_ok), 32'd1);
    wait_cv(1'b0, "window3_period", 101);
    check("window3_count_band", 32'((edge_count >= 16'd10) && (edge_count <= 16'd11)), 32'd1);
    check("window3_fail", 32'(osc_fail), 32'd0);

    // Stuck oscillator: stop just before the window end so the next window is empty
    tick(97);
    osc_period = 0;
    wait_cv(1'b0, "window4_period", 4);
    check("window4_count", 32'(edge_count), 32'd10);
    check("window4_ok", 32'(osc_ok), 32'd1);
    wait_cv(1'b0, "stuck1_period", 101);
    check("stuck1_count", 32'(edge_count), 32'd0);
    check("stuck1_ok_held", 32'(osc_ok), 32'd1);
    check("stuck1_fail", 32'(osc_fail), 32'd0);
    wait_cv(1'b0, "stuck2_period", 101);
    check("stuck2_count", 32'(edge_count), 32'd0);
    check("stuck2_ok", 32'(osc_ok), 32'd0);
    check("stuck2_fail", 32'(osc_fail), 32'd1);
    osc_period = 10;
    wait_cv(1'b0, "recover_period", 101);
    check("recover_count", 32'(edge_count), 32'd10);
    check("recover_ok", 32'(osc_ok), 32'd1);
    check("recover_fail_sticky", 32'(osc_fail), 32'd1);

    // Clear while good, then clear colliding with a failing evaluation
    fail_clr   = 1'b1;
    osc_period = 0;
    tick(1);
    fail_clr = 1'b0;
    check("clear_good", 32'(osc_fail), 32'd0);
    wait_cv(1'b0, "clr_window_period", 100);
    check("clr_window_low", 32'(edge_count <= 16'd1), 32'd1);
    check("clr_window_ok_held", 32'(osc_ok), 32'd1);
    check("clr_window_fail", 32'(osc_fail), 32'd0);
    tick(100);                                 // now in the EVAL cycle
    fail_clr = 1'b1;
    tick(1);
    fail_clr = 1'b0;
    check("set_wins_cv", 32'(count_valid), 32'd1);
    check("set_wins_fail", 32'(osc_fail), 32'd1);
    check("set_wins_ok", 32'(osc_ok), 32'd0);

    // EN abort at window cycle 50
    osc_period = 10;
    wait_cv(1'b0, "pre_abort_period", 101);
    check("pre_abort_count", 32'(edge_count), 32'd10);
    check("pre_abort_ok", 32'(osc_ok), 32'd1);
    tick(50);
    en = 1'b0;
    cv_seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (count_valid === 1'b1) cv_seen++;
    end
    check("abort_no_cv", 32'(cv_seen), 32'd0);
    check("abort_count_held", 32'(edge_count), 32'd10);
    check("abort_ok_held", 32'(osc_ok), 32'd1);
    check("abort_fail_held", 32'(osc_fail), 32'd1);
    en = 1'b1;
    tick(1);                                   // now in MEAS
    wait_cv(1'b0, "reenable_latency", 101);
    check("reenable_count", 32'(edge_count), 32'd10);
    check("reenable_fail", 32'(osc_fail), 32'd1);

    // Reset at window cycle 70 with OK=1 and FAIL=1
    tick(70);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("midrst_edge_count", 32'(edge_count), 32'd0);
    check("midrst_cv", 32'(count_valid), 32'd0);
    check("midrst_ok", 32'(osc_ok), 32'd0);
    check("midrst_fail", 32'(osc_fail), 32'd0);
    tick(1);                                   // release sampled, now in MEAS
    wait_cv(1'b0, "post_rst_latency", 101);
    check("post_rst_count_band", 32'((edge_count >= 16'd10) && (edge_count <= 16'd11)), 32'd1);
    check("post_rst_ok", 32'(osc_ok), 32'd1);
    check("post_rst_fail", 32'(osc_fail), 32'd0);

    // Overspeed with CNT_W=4: count saturates at 15
    en2 = 1'b1;
    tick(1);
    wait_cv(1'b1, "sat1_latency", 101);
    check("sat1_count", 32'(edge_count2), 32'd15);
    check("sat1_ok", 32'(osc_ok2), 32'd0);
    check("sat1_fail", 32'(osc_fail2), 32'd0);
    wait_cv(1'b1, "sat2_period", 101);
    check("sat2_count", 32'(edge_count2), 32'd15);
    check("sat2_fail", 32'(osc_fail2), 32'd1);
    check("sat2_ok", 32'(osc_ok2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
